// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - 3710 single-cycle 16-bit datapath (register file, ALU, flags) and hex 7-seg decoder
module cpu_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic [WIDTH-1:0] instr,
    input  logic             cin,
    input  logic             clk,
    input  logic             reset,
    output logic [4:0]       flags,
    output logic [WIDTH-1:0] rout
);
    typedef enum logic [3:0] {
        K_NOP, K_AND, K_OR, K_XOR, K_ADD, K_ADDC, K_SUB, K_CMP, K_MOV, K_LSH, K_SHL, K_SHR
    } kind_t;

    logic [WIDTH-1:0] regs [NREGS];
    logic [3:0]       op, rd_idx, ext, rs_idx;
    logic [7:0]       imm8;
    logic [WIDTH-1:0] rd_val, rs_val, src, zext_imm, sext_imm, result, shift_mag;
    logic [WIDTH:0]   sum, diff;
    kind_t            kind;
    logic             wr_en;
    logic [4:0]       flags_next;

    assign op       = instr[15:12];
    assign rd_idx   = instr[11:8];
    assign ext      = instr[7:4];
    assign rs_idx   = instr[3:0];
    assign imm8     = instr[7:0];
    assign rd_val   = regs[rd_idx];
    assign rs_val   = regs[rs_idx];
    assign zext_imm = {8'h00, imm8};
    assign sext_imm = {{8{imm8[7]}}, imm8};

    // Decode: every operation reduces to a kind plus a second operand; LUI and MOVI are moves of a formed immediate.
    always_comb begin
        kind = K_NOP;
        src  = rs_val;
        case (op)
            4'b0000: case (ext)
                4'b0001:          kind = K_AND;
                4'b0010:          kind = K_OR;
                4'b0011:          kind = K_XOR;
                4'b0101, 4'b0110: kind = K_ADD;
                4'b0111:          kind = K_ADDC;
                4'b1001:          kind = K_SUB;
                4'b1011:          kind = K_CMP;
                4'b1101:          kind = K_MOV;
                default:          kind = K_NOP;
            endcase
            4'b0001: begin kind = K_AND;  src = zext_imm; end
            4'b0010: begin kind = K_OR;   src = zext_imm; end
            4'b0011: begin kind = K_XOR;  src = zext_imm; end
            4'b0101: begin kind = K_ADD;  src = sext_imm; end
            4'b0110: begin kind = K_ADD;  src = zext_imm; end
            4'b0111: begin kind = K_ADDC; src = sext_imm; end
            4'b1001: begin kind = K_SUB;  src = sext_imm; end
            4'b1011: begin kind = K_CMP;  src = sext_imm; end
            4'b1101: begin kind = K_MOV;  src = zext_imm; end
            4'b1111: begin kind = K_MOV;  src = {imm8, 8'h00}; end
            4'b1000: begin
                if (ext == 4'b0100) begin
                    kind = K_LSH;
                end else if (ext[3:1] == 3'b000) begin
                    kind = ext[0] ? K_SHR : K_SHL;
                end
            end
            default: kind = K_NOP;
        endcase
    end

    always_comb begin
        sum        = {1'b0, rd_val} + {1'b0, src} + {{WIDTH{1'b0}}, (kind == K_ADDC) & cin};
        diff       = {1'b0, rd_val} - {1'b0, src};
        shift_mag  = rs_val[WIDTH-1] ? -rs_val : rs_val;
        result     = '0;
        wr_en      = 1'b0;
        flags_next = flags;
        case (kind)
            K_AND: begin result = rd_val & src; wr_en = 1'b1; end
            K_OR:  begin result = rd_val | src; wr_en = 1'b1; end
            K_XOR: begin result = rd_val ^ src; wr_en = 1'b1; end
            K_MOV: begin result = src;          wr_en = 1'b1; end
            K_ADD, K_ADDC: begin
                result        = sum[WIDTH-1:0];
                wr_en         = 1'b1;
                flags_next[4] = sum[WIDTH-1];
                flags_next[3] = sum[WIDTH];
                flags_next[2] = (rd_val[WIDTH-1] == src[WIDTH-1]) && (sum[WIDTH-1] != rd_val[WIDTH-1]);
                flags_next[1] = (sum[WIDTH-1:0] == '0);
            end
            K_SUB: begin
                result        = diff[WIDTH-1:0];
                wr_en         = 1'b1;
                flags_next[4] = diff[WIDTH-1];
                flags_next[3] = diff[WIDTH];
                flags_next[2] = (rd_val[WIDTH-1] != src[WIDTH-1]) && (diff[WIDTH-1] != rd_val[WIDTH-1]);
                flags_next[1] = (diff[WIDTH-1:0] == '0);
            end
            K_CMP: begin
                flags_next[4] = $signed(rd_val) < $signed(src);
                flags_next[1] = (rd_val == src);
                flags_next[0] = diff[WIDTH];
            end
            K_LSH: begin
                // Shift counts of 16 or more in either direction clear the register.
                wr_en = 1'b1;
                if (shift_mag[WIDTH-1:4] == '0) begin
                    result = rs_val[WIDTH-1] ? (rd_val >> shift_mag[3:0]) : (rd_val << shift_mag[3:0]);
                end
            end
            K_SHL: begin result = rd_val << rs_idx; wr_en = 1'b1; end
            K_SHR: begin result = rd_val >> rs_idx; wr_en = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flags <= '0;
            rout  <= '0;
        end else begin
            flags <= flags_next;
            if (wr_en) begin
                regs[rd_idx] <= result;
                rout         <= result;
            end
        end
    end
endmodule

// Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
module hex_to_seg7 (
    input  logic [3:0] hex_input,
    output logic [6:0] seven_seg_out
);
    always_comb begin
        case (hex_input)
            4'h0: seven_seg_out = 7'b1000000;
            4'h1: seven_seg_out = 7'b1111001;
            4'h2: seven_seg_out = 7'b0100100;
            4'h3: seven_seg_out = 7'b0110000;
            4'h4: seven_seg_out = 7'b0011001;
            4'h5: seven_seg_out = 7'b0010010;
            4'h6: seven_seg_out = 7'b0000010;
            4'h7: seven_seg_out = 7'b1111000;
            4'h8: seven_seg_out = 7'b0000000;
            4'h9: seven_seg_out = 7'b0010000;
            4'hA: seven_seg_out = 7'b0001000;
            4'hB: seven_seg_out = 7'b0000011;
            4'hC: seven_seg_out = 7'b1000110;
            4'hD: seven_seg_out = 7'b0100001;
            4'hE: seven_seg_out = 7'b0000110;
            default: seven_seg_out = 7'b0001110;
        endcase
    end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - scoreboard bench for cpu_datapath with an arithmetic reference model
module tb_cpu_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        cin;
    logic [4:0]  flags;
    logic [15:0] rout;
    logic [6:0]  seg0, seg1, seg2, seg3;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .instr(instr), .cin(cin), .clk(clk), .reset(reset), .flags(flags), .rout(rout)
    );
    hex_to_seg7 u_seg0 (.hex_input(rout[3:0]),   .seven_seg_out(seg0));
    hex_to_seg7 u_seg1 (.hex_input(rout[7:4]),   .seven_seg_out(seg1));
    hex_to_seg7 u_seg2 (.hex_input(rout[11:8]),  .seven_seg_out(seg2));
    hex_to_seg7 u_seg3 (.hex_input(rout[15:12]), .seven_seg_out(seg3));

    typedef struct packed {
        logic [15:0] ins;
        logic [4:0]  fl;
        logic [15:0] ro;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    exp_t        push_e;
    logic [15:0] m_regs [16];
    logic [4:0]  m_flags;
    logic [15:0] m_rout;
    logic [27:0] exp_seg;
    int          vectors = 0;
    int          miscompares = 0;
    logic [6:0]  seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: instruction semantics from the ISA rules using integer arithmetic.
    task automatic model_step(input logic [15:0] ins, input logic ci, input logic rst);
        int         a, b, sa, sb, full, s, res, cadd;
        logic [3:0] op, rd, ex, rs;
        logic [7:0] imm;
        string      k;
        bit         n, c, f, z, l;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_flags = '0;
            m_rout  = '0;
            return;
        end
        op = ins[15:12]; rd = ins[11:8]; ex = ins[7:4]; rs = ins[3:0]; imm = ins[7:0];
        {n, c, f, z, l} = m_flags;
        a  = m_regs[rd];
        sa = $signed(m_regs[rd]);
        b  = m_regs[rs];
        sb = $signed(m_regs[rs]);
        k  = "NOP";
        if (op == 4'h0) begin
            case (ex)
                4'h1: k = "AND";
                4'h2: k = "OR";
                4'h3: k = "XOR";
                4'h5, 4'h6: k = "ADD";
                4'h7: k = "ADDC";
                4'h9: k = "SUB";
                4'hB: k = "CMP";
                4'hD: k = "MOV";
                default: k = "NOP";
            endcase
        end else if (op == 4'h8) begin
            if (ex == 4'h4) k = "LSH";
            else if (ex == 4'h0) k = "LSL";
            else if (ex == 4'h1) k = "LSR";
        end else begin
            case (op)
                4'h1: k = "AND";
                4'h2: k = "OR";
                4'h3: k = "XOR";
                4'h5, 4'h6: k = "ADD";
                4'h7: k = "ADDC";
                4'h9: k = "SUB";
                4'hB: k = "CMP";
                4'hD: k = "MOV";
                4'hF: k = "LUI";
                default: k = "NOP";
            endcase
            if (op == 4'h5 || op == 4'h7 || op == 4'h9 || op == 4'hB)
                sb = (imm >= 128) ? int'(imm) - 256 : int'(imm);
            else
                sb = int'(imm);
            b = sb & 65535;
        end
        res  = -1;
        cadd = (k == "ADDC") ? int'(ci) : 0;
        case (k)
            "AND": res = a & b;
            "OR":  res = a | b;
            "XOR": res = a ^ b;
            "MOV": res = b;
            "LUI": res = int'(imm) * 256;
            "ADD", "ADDC": begin
                full = a + b + cadd;
                s    = sa + sb + cadd;
                res  = full % 65536;
                c = full > 65535; f = (s > 32767) || (s < -32768); z = res == 0; n = res >= 32768;
            end
            "SUB": begin
                full = a - b;
                s    = sa - sb;
                res  = (full + 65536) % 65536;
                c = a < b; f = (s > 32767) || (s < -32768); z = res == 0; n = res >= 32768;
            end
            "CMP": begin
                z = a == b; l = a < b; n = sa < sb;
            end
            "LSH": begin
                if (sb >= 16 || sb <= -16) res = 0;
                else if (sb >= 0) res = (a << sb) % 65536;
                else res = a >> (-sb);
            end
            "LSL": res = (a << rs) % 65536;
            "LSR": res = a >> rs;
            default: ;
        endcase
        m_flags = {n, c, f, z, l};
        if (res >= 0) begin
            m_regs[rd] = res[15:0];
            m_rout     = res[15:0];
        end
    endtask

    task automatic apply(input logic [15:0] ins, input logic ci, input logic rst);
        @(negedge clk);
        instr = ins;
        cin   = ci;
        reset = rst;
        model_step(ins, ci, rst);
        push_e.ins = ins;
        push_e.fl  = m_flags;
        push_e.ro  = m_rout;
        sb_q.push_back(push_e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            exp_seg = {seg_tbl[mon_e.ro[15:12]], seg_tbl[mon_e.ro[11:8]], seg_tbl[mon_e.ro[7:4]], seg_tbl[mon_e.ro[3:0]]};
            vectors++;
            if (rout !== mon_e.ro || flags !== mon_e.fl || {seg3, seg2, seg1, seg0} !== exp_seg) begin
                miscompares++;
                $display("FAIL vec%0d instr=%h: got rout=%h flags=%b seg=%h, expected rout=%h flags=%b seg=%h",
                         vectors, mon_e.ins, rout, flags, {seg3, seg2, seg1, seg0}, mon_e.ro, mon_e.fl, exp_seg);
            end
        end
    end

    task automatic fib_prefix(input int last_k);
        apply(16'h5001, 1'b0, 1'b0);
        apply(16'h5101, 1'b0, 1'b0);
        apply(16'h0150, 1'b0, 1'b0);
        for (int k = 2; k <= last_k; k++) begin
            apply({4'h0, 4'(k), 4'hD, 4'(k - 1)}, 1'b0, 1'b0);
            apply({4'h0, 4'(k), 4'h5, 4'(k - 2)}, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] ins;
        int          sel;
        reset = 1'b1;
        instr = 16'h0000;
        cin   = 1'b0;

        apply(16'(16'h5A5A), 1'b1, 1'b1);
        fib_prefix(15);
        for (int k = 0; k < 16; k++) apply({4'h2, 4'(k), 8'h00}, 1'b0, 1'b0);

        apply(16'h1234, 1'b0, 1'b1);
        apply(16'hF2FF, 1'b0, 1'b0);
        apply(16'h22FF, 1'b0, 1'b0);
        apply(16'h5201, 1'b0, 1'b0);
        apply(16'h0373, 1'b1, 1'b0);
        apply(16'h5101, 1'b0, 1'b0);
        apply(16'hD205, 1'b0, 1'b0);
        apply(16'h01B2, 1'b0, 1'b0);
        foreach (sb_q[i]) ;
        apply(16'h0000, 1'b1, 1'b0);
        apply(16'h0000, 1'b0, 1'b0);
        apply(16'h0000, 1'b1, 1'b0);
        apply(16'h4ABC, 1'b0, 1'b0);
        apply(16'hA123, 1'b1, 1'b0);
        apply(16'hC0FF, 1'b0, 1'b0);
        apply(16'hE777, 1'b0, 1'b0);
        apply(16'h0004, 1'b0, 1'b0);
        apply(16'h8020, 1'b0, 1'b0);

        apply(16'h0000, 1'b0, 1'b1);
        apply(16'h56FD, 1'b0, 1'b0);
        apply(16'hD581, 1'b0, 1'b0);
        apply(16'h8546, 1'b0, 1'b0);
        apply(16'h8504, 1'b0, 1'b0);
        apply(16'h8511, 1'b0, 1'b0);
        apply(16'hD603, 1'b0, 1'b0);
        apply(16'h8546, 1'b0, 1'b0);

        apply(16'h0000, 1'b0, 1'b1);
        fib_prefix(4);
        apply(16'h0205, 1'b0, 1'b1);
        apply(16'h5001, 1'b0, 1'b0);
        apply(16'h2100, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            ins = 16'($urandom);
            if (sel == 5 || sel == 6) begin
                ins[15:12] = 4'h0;
            end else if (sel == 7) begin
                ins[15:12] = 4'h8;
                case ($urandom_range(0, 2))
                    0: ins[7:4] = 4'h4;
                    1: ins[7:4] = 4'h0;
                    default: ins[7:4] = 4'h1;
                endcase
            end else if (sel == 8) begin
                ins[15:12] = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'h9;
                ins[7:0]   = 8'($urandom_range(0, 3)) - 8'd1;
            end
            apply(ins, 1'($urandom), $urandom_range(0, 199) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
